// File: rtl/spiral_unroll.sv
// spiral_unroll: buffers one matrix frame received in clockwise spiral order
// (right, down, left, up, shrinking inward) and re-emits it in row-major order.
// Optional build macro SPIRAL_UNROLL_LAST_EN adds data_out_last, which marks the
// final row-major element of each frame.
module spiral_unroll #(
  parameter int DATA_WIDTH = 8,
  parameter int R_WIDTH    = 3,
  parameter int C_WIDTH    = 3
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [R_WIDTH-1:0]    row,
  input  logic [C_WIDTH-1:0]    col,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_in_valid,
  output logic                  data_in_rdy,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_out_valid,
  input  logic                  data_out_rdy
`ifdef SPIRAL_UNROLL_LAST_EN
  ,
  output logic                  data_out_last
`endif
);

  localparam int MAX_R = 1 << R_WIDTH;
  localparam int MAX_C = 1 << C_WIDTH;
  localparam int CNT_W = R_WIDTH + C_WIDTH;

  typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;
  typedef enum logic [1:0] {RIGHT, DOWN, LEFT, UP} dir_t;

  // Spiral write cursor together with the shrinking boundary box.
  typedef struct packed {
    logic [R_WIDTH-1:0] r;
    logic [R_WIDTH-1:0] top;
    logic [R_WIDTH-1:0] bot;
    logic [C_WIDTH-1:0] c;
    logic [C_WIDTH-1:0] lft;
    logic [C_WIDTH-1:0] rgt;
    dir_t               dir;
  } walk_t;

  state_t                  state;
  walk_t                   walk, init_walk;
  logic [R_WIDTH-1:0]      row_q, rd_r;
  logic [C_WIDTH-1:0]      col_q, rd_c;
  logic [CNT_W-1:0]        count, total, total_nx;
  logic [DATA_WIDTH-1:0]   mem [MAX_R][MAX_C];
  logic                    in_beat;

  // Advance the cursor one step; on reaching a box edge, turn clockwise and
  // pull the edge just completed inward.
  function automatic walk_t step(input walk_t w);
    walk_t n;
    n = w;
    case (w.dir)
      RIGHT: if (w.c == w.rgt) begin n.top = w.top + 1'b1; n.r = w.r + 1'b1; n.dir = DOWN;  end
             else n.c = w.c + 1'b1;
      DOWN:  if (w.r == w.bot) begin n.rgt = w.rgt - 1'b1; n.c = w.c - 1'b1; n.dir = LEFT;  end
             else n.r = w.r + 1'b1;
      LEFT:  if (w.c == w.lft) begin n.bot = w.bot - 1'b1; n.r = w.r - 1'b1; n.dir = UP;    end
             else n.c = w.c - 1'b1;
      UP:    if (w.r == w.top) begin n.lft = w.lft + 1'b1; n.c = w.c + 1'b1; n.dir = RIGHT; end
             else n.r = w.r - 1'b1;
    endcase
    return n;
  endfunction

  assign in_beat  = data_in_valid & data_in_rdy;
  assign data_out = mem[rd_r][rd_c];
`ifdef SPIRAL_UNROLL_LAST_EN
  assign data_out_last = data_out_valid && (rd_r == row_q - 1'b1) && (rd_c == col_q - 1'b1);
`endif

  // Cursor and frame size seeded from the dimensions presented with the first beat.
  always_comb begin
    init_walk     = '0;
    init_walk.bot = row - 1'b1;
    init_walk.rgt = col - 1'b1;
    init_walk.dir = RIGHT;
    total_nx      = CNT_W'(row) * CNT_W'(col);
  end

  // Frame FSM: collect in spiral order, then drain row-major; no overlap.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state          <= IDLE;
      data_in_rdy    <= 1'b0;
      data_out_valid <= 1'b0;
      row_q          <= '0;
      col_q          <= '0;
      total          <= '0;
      count          <= '0;
      walk           <= '0;
      rd_r           <= '0;
      rd_c           <= '0;
      for (int i = 0; i < MAX_R; i++)
        for (int j = 0; j < MAX_C; j++)
          mem[i][j] <= '0;
    end else begin
      case (state)
        IDLE: begin
          data_in_rdy <= 1'b1;
          if (in_beat) begin
            row_q     <= row;
            col_q     <= col;
            total     <= total_nx;
            count     <= CNT_W'(1);
            mem[0][0] <= data_in;
            walk      <= step(init_walk);
            rd_r      <= '0;
            rd_c      <= '0;
            if (total_nx == CNT_W'(1)) begin
              state          <= DRAIN;
              data_in_rdy    <= 1'b0;
              data_out_valid <= 1'b1;
            end else begin
              state <= FILL;
            end
          end
        end
        FILL: begin
          if (in_beat) begin
            mem[walk.r][walk.c] <= data_in;
            count               <= count + 1'b1;
            // Fill ends on count alone, so thin frames may stop mid-direction.
            if (count == total - 1'b1) begin
              state          <= DRAIN;
              data_in_rdy    <= 1'b0;
              data_out_valid <= 1'b1;
              rd_r           <= '0;
              rd_c           <= '0;
            end else begin
              walk <= step(walk);
            end
          end
        end
        DRAIN: begin
          if (data_out_rdy) begin
            if (rd_c == col_q - 1'b1) begin
              rd_c <= '0;
              if (rd_r == row_q - 1'b1) begin
                state          <= IDLE;
                data_out_valid <= 1'b0;
                data_in_rdy    <= 1'b1;
                rd_r           <= '0;
              end else begin
                rd_r <= rd_r + 1'b1;
              end
            end else begin
              rd_c <= rd_c + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef SYNTHESIS
  // Zero-sized frames are illegal; catch them on the frame's first beat.
  always_ff @(posedge clk) begin
    if (rstn && in_beat && state == IDLE)
      assert (row != '0 && col != '0);
  end
`endif

endmodule

// File: tb/tb_spiral_unroll.sv
// Testbench for spiral_unroll: spiral-order frames generated from row-major
// matrices by a boundary-walk model, output compared against row-major order.
module tb_spiral_unroll;

  logic       clk = 1'b0;
  logic       rstn;
  logic [2:0] row, col;
  logic [7:0] data_in, data_out;
  logic       data_in_valid, data_in_rdy, data_out_valid, data_out_rdy;
`ifdef SPIRAL_UNROLL_LAST_EN
  logic       data_out_last;
`endif

  int errors = 0;
  int checks = 0;

  spiral_unroll #(.DATA_WIDTH(8), .R_WIDTH(3), .C_WIDTH(3)) dut (
    .clk(clk), .rstn(rstn), .row(row), .col(col),
    .data_in(data_in), .data_in_valid(data_in_valid), .data_in_rdy(data_in_rdy),
    .data_out(data_out), .data_out_valid(data_out_valid), .data_out_rdy(data_out_rdy)
`ifdef SPIRAL_UNROLL_LAST_EN
    , .data_out_last(data_out_last)
`endif
  );

  always #5 clk = ~clk;

  // Build nf frames of r x c, stream them in spiral order and check row-major out.
  // mode 0: sequential values from base; 1: random. rmode 0: rdy=1, 1: toggle, 2: random.
  task automatic run_stream(input int r, input int c, input int nf, input int mode,
                            input int base, input bit gaps, input int rmode, input string name);
    logic [7:0] sin[$];
    logic [7:0] ex[$];
    int m[8][8];
    int n, idx, got, cyc, t, b, l, rt;
    bit vexp, rexp, pstall;
    logic [7:0] pdata;
    n = r * c;
    for (int f = 0; f < nf; f++) begin
      for (int i = 0; i < r; i++)
        for (int j = 0; j < c; j++) begin
          m[i][j] = (mode != 0) ? int'($urandom_range(255)) : base + f * n + i * c + j;
          ex.push_back(8'(m[i][j]));
        end
      t = 0; b = r - 1; l = 0; rt = c - 1;
      while (t <= b && l <= rt) begin
        for (int j = l; j <= rt; j++) sin.push_back(8'(m[t][j]));
        t++;
        for (int i = t; i <= b; i++) sin.push_back(8'(m[i][rt]));
        rt--;
        if (t <= b) begin
          for (int j = rt; j >= l; j--) sin.push_back(8'(m[b][j]));
          b--;
        end
        if (l <= rt) begin
          for (int i = b; i >= t; i--) sin.push_back(8'(m[i][l]));
          l++;
        end
      end
    end
    idx = 0; got = 0; cyc = 0; vexp = 0; rexp = 0; pstall = 0; pdata = '0;
    while (got < n * nf && cyc < n * nf * 8 + 64) begin
      @(negedge clk);
      if (idx < n * nf) begin
        data_in_valid = gaps ? ($urandom_range(3) != 0) : 1'b1;
        data_in = sin[idx];
        if (idx % n == 0) begin row = 3'(r); col = 3'(c); end
        else begin row = 3'($urandom_range(7, 1)); col = 3'($urandom_range(7, 1)); end
      end else begin
        data_in_valid = 1'b0;
      end
      case (rmode)
        0:       data_out_rdy = 1'b1;
        1:       data_out_rdy = (cyc % 2 == 0);
        default: data_out_rdy = 1'($urandom_range(1));
      endcase
      #1;
      if (vexp) begin
        checks++;
        if (data_out_valid !== 1'b1 || data_in_rdy !== 1'b0)
          $display("FAIL %s latency: valid=%b rdy=%b, required valid=1 rdy=0", name, data_out_valid, data_in_rdy);
        vexp = 0;
      end
      if (rexp) begin
        checks++;
        if (data_in_rdy !== 1'b1) begin
          errors++;
          $display("FAIL %s turnaround: in_rdy=%b, required 1", name, data_in_rdy);
        end
        rexp = 0;
      end
      checks++;
      if (data_out_valid === 1'b1 && data_in_rdy === 1'b1) begin
        errors++;
        $display("FAIL %s overlap: in_rdy and out_valid both 1", name);
      end
      if (data_in_valid && data_in_rdy === 1'b1) begin
        idx++;
        if (idx % n == 0) vexp = 1;
      end
      if (data_out_valid === 1'b1) begin
        checks++;
        if (data_out !== ex[got]) begin
          errors++;
          $display("FAIL %s data[%0d]: got %0d, required %0d", name, got, data_out, ex[got]);
        end
        if (pstall) begin
          checks++;
          if (data_out !== pdata) begin
            errors++;
            $display("FAIL %s hold: got %0d, required %0d", name, data_out, pdata);
          end
        end
`ifdef SPIRAL_UNROLL_LAST_EN
        checks++;
        if (data_out_last !== 1'((got % n) == n - 1)) begin
          errors++;
          $display("FAIL %s last[%0d]: got %b, required %b", name, got, data_out_last, (got % n) == n - 1);
        end
`endif
        pstall = !data_out_rdy;
        pdata  = data_out;
        if (data_out_rdy) begin
          got++;
          if (got % n == 0 && got < n * nf) rexp = 1;
        end
      end else begin
        pstall = 0;
      end
      cyc++;
    end
    checks++;
    if (got != n * nf) begin
      errors++;
      $display("FAIL %s timeout: got %0d outputs, required %0d", name, got, n * nf);
    end
    // The loop exits before the edge that takes the last output beat.
    @(negedge clk);
    data_in_valid = 1'b0;
    data_out_rdy  = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; data_in_valid = 1'b0; data_out_rdy = 1'b0;
    row = 3'd1; col = 3'd1; data_in = '0;
    #12;
    checks++;
    if (data_in_rdy !== 1'b0 || data_out_valid !== 1'b0 || data_out !== 8'd0) begin
      errors++;
      $display("FAIL reset_vals: rdy=%b valid=%b out=%0d, required 0 0 0", data_in_rdy, data_out_valid, data_out);
    end
    @(negedge clk); rstn = 1'b1; #1;
    checks++;
    if (data_in_rdy !== 1'b0) begin
      errors++;
      $display("FAIL reset_pre_edge_rdy: got %b, required 0", data_in_rdy);
    end
    @(negedge clk); #1;
    checks++;
    if (data_in_rdy !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_edge_rdy: got %b, required 1", data_in_rdy);
    end
  endtask

  task automatic test_directed();
    run_stream(3, 3, 1, 0, 1, 1'b0, 0, "f3x3");
    run_stream(1, 4, 1, 0, 10, 1'b0, 0, "f1x4");
    run_stream(4, 1, 1, 0, 20, 1'b0, 0, "f4x1");
    run_stream(1, 1, 1, 0, 77, 1'b0, 0, "f1x1");
    run_stream(7, 7, 1, 1, 0, 1'b0, 0, "f7x7");
  endtask

  task automatic test_backpressure();
    run_stream(3, 4, 1, 0, 1, 1'b0, 1, "bp3x4");
  endtask

  task automatic test_back_to_back();
    run_stream(2, 2, 3, 0, 40, 1'b0, 0, "b2b2x2");
  endtask

  task automatic test_reset_mid();
    logic [7:0] seq [9];
    int k, cyc;
    seq = '{8'd1, 8'd2, 8'd3, 8'd6, 8'd9, 8'd8, 8'd7, 8'd4, 8'd5};
    k = 0; cyc = 0;
    while (k < 5 && cyc < 40) begin
      @(negedge clk);
      data_in_valid = 1'b1; data_in = seq[k]; row = 3'd3; col = 3'd3; data_out_rdy = 1'b1;
      #1;
      if (data_in_rdy === 1'b1) k++;
      cyc++;
    end
    @(negedge clk);
    data_in_valid = 1'b0;
    #2 rstn = 1'b0;
    #1;
    checks++;
    if (data_in_rdy !== 1'b0 || data_out_valid !== 1'b0 || data_out !== 8'd0) begin
      errors++;
      $display("FAIL rst_mid_async: rdy=%b valid=%b out=%0d, required 0 0 0", data_in_rdy, data_out_valid, data_out);
    end
    @(negedge clk); rstn = 1'b1;
    run_stream(2, 2, 1, 0, 100, 1'b0, 0, "after_rst");
  endtask

  task automatic test_last();
    run_stream(2, 3, 1, 0, 50, 1'b0, 2, "last2x3");
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++)
      run_stream(int'($urandom_range(7, 1)), int'($urandom_range(7, 1)), 1, 1, 0, 1'b1, 2, "rand");
    run_stream(int'($urandom_range(7, 1)), int'($urandom_range(7, 1)), 3, 1, 0, 1'b1, 2, "rand_multi");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_last();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
